// File: rtl/alu3_pkg.sv
// Shared types, widths and datapath helpers for the two-requester ALU/BCD arbiter.
package alu3_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned RES_W = 4;
    localparam int unsigned BCD_W = 8;
    localparam int unsigned N_REQ = 2;
    localparam int unsigned DD_W  = BCD_W + RES_W;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_MAX = 2'd2,
        MODE_AND = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CONV = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Four-bit ALU result; subtraction wraps modulo 16.
    function automatic logic [RES_W-1:0] alu_eval(input mode_e mode,
                                                  input logic [OP_W-1:0] a,
                                                  input logic [OP_W-1:0] b);
        logic [RES_W-1:0] res;
        case (mode)
            MODE_ADD: res = RES_W'(a) + RES_W'(b);
            MODE_SUB: res = RES_W'(a) - RES_W'(b);
            MODE_MAX: res = (a >= b) ? RES_W'(a) : RES_W'(b);
            MODE_AND: res = RES_W'(a & b);
            default:  res = '0;
        endcase
        return res;
    endfunction

    // One double-dabble iteration on {tens, ones, binary}: add-3 then shift left.
    function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] w);
        logic [DD_W-1:0] t;
        t = w;
        if (t[11:8] >= 4'd5) t[11:8] = t[11:8] + 4'd3;
        if (t[7:4]  >= 4'd5) t[7:4]  = t[7:4]  + 4'd3;
        return {t[DD_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/alu3_bcd_serial.sv
// Four-cycle iterative binary-to-BCD converter; the first shift happens on the start edge.
module alu3_bcd_serial
    import alu3_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [RES_W-1:0] value,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [DD_W-1:0] work;
    logic [DD_W-1:0] step_w;
    logic [1:0]      cnt;
    logic            running;

    // Next iteration of the working register.
    always_comb begin
        step_w = dd_step(work);
    end

    // Shift sequencer; bcd only changes when a conversion completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work    <= '0;
            cnt     <= 2'd0;
            running <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
        end else if (start) begin
            work    <= dd_step({BCD_W'(0), value});
            cnt     <= 2'd1;
            running <= 1'b1;
            done    <= 1'b0;
        end else if (running) begin
            if (cnt == 2'd3) begin
                bcd     <= step_w[DD_W-1:RES_W];
                running <= 1'b0;
                done    <= 1'b1;
            end else begin
                work <= step_w;
                cnt  <= cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/alu3_req_arbiter.sv
// Two-requester arbiter sharing one 3-bit ALU and serial BCD converter.
// Define ALU3_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu3_req_arbiter
    import alu3_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [5:0] req_left,
    input  logic [5:0] req_right,
    input  logic [3:0] req_mode,
    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic [3:0] rsp_bin,
    output logic [7:0] rsp_bcd,
    output logic [7:0] disp_bcd,
    output logic       busy
);

    state_e          state;
    logic            gidx;
    logic [OP_W-1:0] lat_left;
    logic [OP_W-1:0] lat_right;
    mode_e           lat_mode;
    logic [1:0]      cnt;
    logic [1:0]      grant;
    logic            sel;
    logic            rsp_ready_g;
    logic            bcd_start;
    logic            bcd_done;
    logic [BCD_W-1:0] bcd;
`ifndef ALU3_ARB_FIXED_PRIO_EN
    logic            last;
`endif

    // Grant selection among valid requesters.
    always_comb begin
        grant = 2'b00;
`ifdef ALU3_ARB_FIXED_PRIO_EN
        if (req_valid[0])      grant = 2'b01;
        else if (req_valid[1]) grant = 2'b10;
`else
        if (req_valid == 2'b11) grant = last ? 2'b01 : 2'b10;
        else                    grant = req_valid;
`endif
    end

    // Accept strobe, held quiet outside IDLE and while reset is asserted.
    always_comb begin
        req_ready = 2'b00;
        if (state == ST_IDLE && rst_n) req_ready = grant & req_valid;
    end

    // Payload mux, response-ready select and converter kick-off.
    always_comb begin
        sel         = req_ready[1];
        rsp_ready_g = gidx ? rsp_ready[1] : rsp_ready[0];
        bcd_start   = (state == ST_CONV) && (cnt == 2'd0);
    end

    assign rsp_bcd = bcd;

    // Control FSM with registered datapath and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gidx      <= 1'b0;
            lat_left  <= '0;
            lat_right <= '0;
            lat_mode  <= MODE_ADD;
            cnt       <= 2'd0;
            rsp_bin   <= '0;
            rsp_valid <= 2'b00;
            disp_bcd  <= '0;
            busy      <= 1'b0;
`ifndef ALU3_ARB_FIXED_PRIO_EN
            last      <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_ready) begin
                        gidx      <= sel;
                        lat_left  <= sel ? req_left[5:3]  : req_left[2:0];
                        lat_right <= sel ? req_right[5:3] : req_right[2:0];
                        lat_mode  <= mode_e'(sel ? req_mode[3:2] : req_mode[1:0]);
                        busy      <= 1'b1;
`ifndef ALU3_ARB_FIXED_PRIO_EN
                        last      <= sel;
`endif
                        state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_bin <= alu_eval(lat_mode, lat_left, lat_right);
                    cnt     <= 2'd0;
                    state   <= ST_CONV;
                end
                ST_CONV: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        rsp_valid <= gidx ? 2'b10 : 2'b01;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready_g) begin
                        rsp_valid <= 2'b00;
                        busy      <= 1'b0;
                        if (bcd_done) disp_bcd <= bcd;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    alu3_bcd_serial u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (bcd_start),
        .value (rsp_bin),
        .done  (bcd_done),
        .bcd   (bcd)
    );

endmodule

// File: tb/tb_alu3_req_arbiter.sv
// Randomized self-checking bench for alu3_req_arbiter against an arithmetic reference model.
module tb_alu3_req_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [5:0] req_left;
    logic [5:0] req_right;
    logic [3:0] req_mode;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [3:0] rsp_bin;
    logic [7:0] rsp_bcd;
    logic [7:0] disp_bcd;
    logic       busy;

    int         n_checks = 0;
    int         n_errors = 0;
    int         mdl_last = 1;
    logic [7:0] mdl_disp = 8'h00;

    always #5 clk = ~clk;

    alu3_req_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_left  (req_left),
        .req_right (req_right),
        .req_mode  (req_mode),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_bin   (rsp_bin),
        .rsp_bcd   (rsp_bcd),
        .disp_bcd  (disp_bcd),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_alu(input int a, input int b, input int m);
        case (m)
            0:       return (a + b) % 16;
            1:       return (a - b + 16) % 16;
            2:       return (a >= b) ? a : b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int pick(input logic [1:0] mask);
`ifdef ALU3_ARB_FIXED_PRIO_EN
        return mask[0] ? 0 : 1;
`else
        if (mask == 2'b11) return (mdl_last == 0) ? 1 : 0;
        return mask[0] ? 0 : 1;
`endif
    endfunction

    // Assert reset, check every output is cleared, release on a falling edge.
    task automatic apply_reset(input logic [1:0] hold_valid);
        rst_n     = 1'b0;
        req_valid = hold_valid;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_bin",   rsp_bin,   0);
        check("rst_rsp_bcd",   rsp_bcd,   0);
        check("rst_disp_bcd",  disp_bcd,  0);
        check("rst_busy",      busy,      0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 2'b00;
        mdl_last  = 1;
        mdl_disp  = 8'h00;
        #2;
    endtask

    // One full request/response transaction checked against the model.
    task automatic run_txn(input logic [1:0] mask, input logic [5:0] l, input logic [5:0] r,
                           input logic [3:0] m, input int stall, output int gidx);
        int         g;
        int         tries;
        int         exp_bin;
        logic [7:0] exp_bcd;
        logic [1:0] oh;
        req_valid = mask;
        req_left  = l;
        req_right = r;
        req_mode  = m;
        #1;
        tries = 0;
        while (req_ready == 2'b00 && tries < 10) begin
            @(negedge clk);
            #2;
            tries++;
        end
        if (req_ready == 2'b00) begin
            check("accept_timeout", 0, 1);
            req_valid = 2'b00;
            gidx = -1;
            return;
        end
        g  = pick(mask);
        oh = (g == 1) ? 2'b10 : 2'b01;
        check("grant", req_ready, oh);
        gidx    = req_ready[1] ? 1 : 0;
        exp_bin = exp_alu(int'(g ? l[5:3] : l[2:0]), int'(g ? r[5:3] : r[2:0]),
                          int'(g ? m[3:2] : m[1:0]));
        exp_bcd = to_bcd(exp_bin);
        @(posedge clk);
        mdl_last = g;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            req_valid = 2'($urandom);
            req_left  = 6'($urandom);
            req_right = 6'($urandom);
            req_mode  = 4'($urandom);
            #2;
            check("busy_req_ready", req_ready, 0);
            check("latency_valid", rsp_valid, (k < 6) ? 2'b00 : oh);
        end
        check("rsp_bin", rsp_bin, exp_bin);
        check("rsp_bcd", rsp_bcd, exp_bcd);
        check("busy", busy, 1);
        for (int s = 0; s < stall; s++) begin
            rsp_ready = ~oh & 2'($urandom);
            @(negedge clk);
            #2;
            check("stall_valid", rsp_valid, oh);
            check("stall_bcd", rsp_bcd, exp_bcd);
            check("stall_bin", rsp_bin, exp_bin);
            check("stall_disp", disp_bcd, mdl_disp);
            check("stall_req_ready", req_ready, 0);
        end
        rsp_ready = oh | 2'($urandom);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 2'b00;
        req_valid = 2'b00;
        #2;
        mdl_disp = exp_bcd;
        check("disp_bcd", disp_bcd, mdl_disp);
        check("post_valid", rsp_valid, 0);
        check("post_busy", busy, 0);
    endtask

    // Stimulus sequence.
    initial begin
        int gi;
        rst_n     = 1'b1;
        req_valid = 2'b00;
        req_left  = '0;
        req_right = '0;
        req_mode  = '0;
        rsp_ready = 2'b00;
        #3;
        apply_reset(2'b11);

        run_txn(2'b01, {3'd0, 3'd5}, {3'd0, 3'd6}, {2'd0, 2'd0}, 0, gi);
        run_txn(2'b10, {3'd2, 3'd0}, {3'd5, 3'd0}, {2'd1, 2'd0}, 0, gi);
        run_txn(2'b10, {3'd7, 3'd0}, {3'd3, 3'd0}, {2'd2, 2'd0}, 0, gi);
        run_txn(2'b10, {3'd6, 3'd0}, {3'd3, 3'd0}, {2'd3, 2'd0}, 0, gi);

        apply_reset(2'b00);
        for (int i = 0; i < 4; i++) begin
            run_txn(2'b11, 6'($urandom), 6'($urandom), 4'($urandom), 0, gi);
`ifdef ALU3_ARB_FIXED_PRIO_EN
            check("grant_seq", gi, 0);
`else
            check("grant_seq", gi, i % 2);
`endif
        end

        run_txn(2'b01, 6'($urandom), 6'($urandom), 4'($urandom), 20, gi);

        for (int i = 0; i < 30; i++) begin
            run_txn(2'($urandom_range(1, 3)), 6'($urandom), 6'($urandom), 4'($urandom),
                    int'($urandom_range(0, 3)), gi);
        end

        // Reset while converting: everything clears and no stale response follows.
        req_valid = 2'b01;
        req_left  = {3'd0, 3'd5};
        req_right = {3'd0, 3'd6};
        req_mode  = 4'd0;
        #1;
        check("midrst_accept", req_ready, 2'b01);
        @(posedge clk);
        repeat (3) @(negedge clk);
        #1;
        check("midrst_busy", busy, 1);
        apply_reset(2'b11);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #2;
            check("midrst_no_rsp", rsp_valid, 0);
            check("midrst_idle", busy, 0);
        end
        run_txn(2'b11, 6'($urandom), 6'($urandom), 4'($urandom), 0, gi);
        check("midrst_first_grant", gi, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
